// File: rtl/instruction_encoder.sv
// Packs R/I/J field tuples into 32-bit MIPS words, queues them in a small FIFO
// and streams them to instruction memory at consecutive word addresses.
module instruction_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 fmt,
  input  logic [5:0]                 Opp,
  input  logic [4:0]                 Rs,
  input  logic [4:0]                 Rt,
  input  logic [4:0]                 Rd,
  input  logic [4:0]                 Shamt,
  input  logic [5:0]                 Func,
  input  logic [15:0]                Imm,
  input  logic [25:0]                Jaddress,
  output logic                       mem_we,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       fifo_q [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic [31:0]       word_d;
  logic              hs, push, pop;

  always_comb begin
    word_d = '0;
    case (fmt)
      2'd0:    word_d = {Opp, Rs, Rt, Rd, Shamt, Func};
      2'd1:    word_d = {Opp, Rs, Rt, Imm};
      2'd2:    word_d = {Opp, Jaddress};
      default: word_d = '0;
    endcase
  end

  assign in_ready = (count_q < CW'(DEPTH));
  assign mem_we   = (count_q != '0);
  assign hs       = in_valid & in_ready;
  // An illegal format still completes the handshake but never enters the queue.
  assign push     = hs & (fmt != 2'd3);
  assign pop      = mem_we & mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        addr_q <= addr_q + ADDR_W'(4);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (hs && fmt == 2'd3) err_q <= 1'b1;
    end
  end

  // Storage needs no reset: the head is only exposed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (!clear && push) fifo_q[wptr_q] <= word_d;
  end

  assign mem_wdata = mem_we ? fifo_q[rptr_q] : 32'h0;
  assign mem_addr  = addr_q;
  assign count     = count_q;
  assign err       = err_q;
endmodule
